// File: rtl/add8b_seq.sv
// Bit-serial adder: iJ + iK + iC, one bit per clock, LSB first.
// Reports per-bit carries and even parity alongside the registered sum.
module add8b_seq #(
  parameter int DATASIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [DATASIZE-1:0] iJ,
  input  logic [DATASIZE-1:0] iK,
  input  logic                iC,
  output logic                oBusy,
  output logic                oDone,
  output logic [DATASIZE-1:0] oD,
  output logic [DATASIZE-1:0] oC,
  output logic                oP
);

  localparam int CW = $clog2(DATASIZE);
  localparam logic [CW-1:0] LAST = CW'(DATASIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATASIZE-1:0] r_j;
  logic [DATASIZE-1:0] r_k;
  logic [DATASIZE-1:0] r_sum;
  logic [DATASIZE-1:0] r_cv;
  logic [DATASIZE-1:0] r_d;
  logic [DATASIZE-1:0] r_c;
  logic                r_cin;
  logic [CW-1:0]       r_cnt;

  logic                w_accept;
  logic                w_last;
  logic                w_jb;
  logic                w_kb;
  logic                w_s;
  logic                w_co;
  logic [DATASIZE-1:0] w_sum;
  logic [DATASIZE-1:0] w_cv;

  assign w_jb   = r_j[r_cnt];
  assign w_kb   = r_k[r_cnt];
  assign w_s    = w_jb ^ w_kb ^ r_cin;
  assign w_co   = (w_jb & w_kb) | (w_jb & r_cin) | (w_kb & r_cin);
  assign w_last = (r_cnt == LAST);

  // Current bit merged into the partial results so the final bit can be
  // published on the same edge that enters DONE.
  always_comb begin
    w_sum        = r_sum;
    w_cv         = r_cv;
    w_sum[r_cnt] = w_s;
    w_cv[r_cnt]  = w_co;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    oBusy    = 1'b0;
    oDone    = 1'b0;
    case (r_state)
      IDLE: begin
        if (iStart) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        oBusy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        oDone = 1'b1;
        if (iStart) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_j   <= '0;
      r_k   <= '0;
      r_sum <= '0;
      r_cv  <= '0;
      r_d   <= '0;
      r_c   <= '0;
      r_cin <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_j   <= iJ;
      r_k   <= iK;
      r_cin <= iC;
      r_sum <= '0;
      r_cv  <= '0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_sum <= w_sum;
      r_cv  <= w_cv;
      r_cin <= w_co;
      if (w_last) begin
        r_d <= w_sum;
        r_c <= w_cv;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign oD = r_d;
  assign oC = r_c;
  assign oP = ~^r_d;

endmodule
